// File: rtl/div_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl_pkg
//   Shared types and constants for the divide issue controller and its
//   pipelined divider datapath.
//     div_op_t        : opcode encoding presented by decode
//     DIV_LATENCY     : default number of divider register stages
//     shadow_entry_t  : per-stage sideband carried alongside the divider
//     div_stage_t     : per-stage divider working state
// ---------------------------------------------------------------------------
package div_issue_ctrl_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned DIV_LATENCY = 8;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       is_rem;
    logic       dz;
  } shadow_entry_t;

  // quo starts as |dividend| and is shifted out MSB-first while quotient
  // bits are shifted in at the LSB; rem is the partial remainder.
  typedef struct packed {
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvsr;
    logic            neg_q;
    logic            neg_r;
  } div_stage_t;

endpackage

// File: rtl/div_issue_ctrl_divider.sv
// ---------------------------------------------------------------------------
// DividerPipelined
//   Restoring radix-2 divider spread over LATENCY register stages. Each stage
//   resolves ceil(32/LATENCY) quotient bits. Operands are converted to
//   magnitudes at the input and signs are re-applied at the output, so:
//     x / 0  -> quotient magnitude all-ones, remainder = x
//     INT_MIN / -1 -> quotient 0x8000_0000, remainder 0
//   Ports:
//     clk, rst         : clock, synchronous active-high reset of stage data
//     stall            : freeze every stage
//     i_signed         : treat operands as two's complement
//     i_dividend/i_divisor : operands, captured every non-stalled cycle
//     o_quotient/o_remainder : results of the operation LATENCY cycles back
// ---------------------------------------------------------------------------
module DividerPipelined #(
  parameter int unsigned LATENCY = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        i_signed,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);
  import div_issue_ctrl_pkg::*;

  localparam int unsigned BPS = (XLEN + LATENCY - 1) / LATENCY;

  div_stage_t entry;
  div_stage_t last;
  logic       neg_a;
  logic       neg_b;

  always_comb begin
    neg_a       = i_signed & i_dividend[XLEN-1];
    neg_b       = i_signed & i_divisor[XLEN-1];
    entry       = '0;
    entry.quo   = neg_a ? -i_dividend : i_dividend;
    entry.dvsr  = neg_b ? -i_divisor  : i_divisor;
    entry.neg_q = neg_a ^ neg_b;
    entry.neg_r = neg_a;
  end

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    localparam int unsigned FIRST_BIT = s * BPS;

    div_stage_t      stage_in;
    div_stage_t      stage_d;
    div_stage_t      stage_q;
    logic [XLEN:0]   trial;

    if (s == 0) begin : g_first
      assign stage_in = entry;
    end else begin : g_next
      assign stage_in = g_stage[s-1].stage_q;
    end

    // The last stage may carry fewer than BPS iterations when LATENCY does
    // not divide 32; excess iterations pass the state through untouched.
    always_comb begin
      stage_d = stage_in;
      trial   = '0;
      for (int unsigned j = 0; j < BPS; j++) begin
        if (FIRST_BIT + j < XLEN) begin
          trial       = {stage_d.rem, stage_d.quo[XLEN-1]};
          stage_d.quo = {stage_d.quo[XLEN-2:0], 1'b0};
          if (trial >= {1'b0, stage_d.dvsr}) begin
            // Difference is below dvsr, so 32-bit wraparound is exact.
            stage_d.rem    = trial[XLEN-1:0] - stage_d.dvsr;
            stage_d.quo[0] = 1'b1;
          end else begin
            stage_d.rem = trial[XLEN-1:0];
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        stage_q <= '0;
      end else if (!stall) begin
        stage_q <= stage_d;
      end
    end
  end

  assign last        = g_stage[LATENCY-1].stage_q;
  assign o_quotient  = last.neg_q ? -last.quo : last.quo;
  assign o_remainder = last.neg_r ? -last.rem : last.rem;

endmodule

// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
//   Issue/response controller around a fully pipelined divider. A shadow
//   pipe of DIV_LATENCY entries travels in lockstep with the divider stages
//   and carries valid, destination tag and result-selection sideband.
//   Ports:
//     clk, rst_n            : clock, synchronous active-low reset
//     req_valid/req_ready   : request handshake from decode
//     req_op, req_rs1/rs2   : opcode (DIV/DIVU/REM/REMU) and operands
//     req_rd                : destination tag
//     flush                 : kill every in-flight operation
//     resp_valid/resp_ready : result handshake to writeback
//     resp_rd, resp_data    : result tag and value
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
  parameter int unsigned DIV_LATENCY = div_issue_ctrl_pkg::DIV_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data
);
  import div_issue_ctrl_pkg::*;

  div_op_t       op;
  shadow_entry_t pipe_q [DIV_LATENCY];
  shadow_entry_t entry_d;
  shadow_entry_t tail;
  logic          hold;
  logic          op_signed;
  logic [31:0]   div_quo;
  logic [31:0]   div_rem;

  assign op        = div_op_t'(req_op);
  assign op_signed = (op == OP_DIV) || (op == OP_REM);
  assign tail      = pipe_q[DIV_LATENCY-1];

  // A result waiting at the tail freezes the whole pipe and the divider.
  assign hold      = tail.v & ~resp_ready;
  assign req_ready = ~hold & ~flush;

  always_comb begin
    entry_d        = '0;
    entry_d.v      = req_valid & req_ready;
    entry_d.rd     = req_rd;
    entry_d.is_rem = (op == OP_REM) || (op == OP_REMU);
    entry_d.dz     = (req_rs2 == '0) & ~entry_d.is_rem;
  end

  // Flush only drops valid bits; tags and divider data are left in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DIV_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < DIV_LATENCY; i++) begin
        pipe_q[i].v <= 1'b0;
      end
    end else if (!hold) begin
      pipe_q[0] <= entry_d;
      for (int unsigned i = 1; i < DIV_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  DividerPipelined #(
    .LATENCY (DIV_LATENCY)
  ) u_divider (
    .clk         (clk),
    .rst         (~rst_n),
    .stall       (hold),
    .i_signed    (op_signed),
    .i_dividend  (req_rs1),
    .i_divisor   (req_rs2),
    .o_quotient  (div_quo),
    .o_remainder (div_rem)
  );

  assign resp_valid = tail.v;
  assign resp_rd    = tail.rd;

  // Remainder by zero already equals the dividend from the datapath; only
  // the quotient needs the all-ones override.
  always_comb begin
    if (tail.is_rem) begin
      resp_data = div_rem;
    end else if (tail.dz) begin
      resp_data = '1;
    end else begin
      resp_data = div_quo;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_issue_ctrl
//   Scoreboard bench: accepted requests push the arithmetic result and the
//   acceptance time; a negedge monitor checks every presented response
//   against the queue head, including timing and stability under backpressure.
// ---------------------------------------------------------------------------
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  localparam int unsigned LAT = 8;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          acc_cyc;
    int          hold_at;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   cyc        = 0;
  int   hold_count = 0;
  bit   held_now   = 0;

  div_issue_ctrl #(
    .DIV_LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rd     (req_rd),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rd    (resp_rd),
    .resp_data  (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural divide semantics, written directly from the ISA rules.
  function automatic logic [31:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0:    if (b == 0) return 32'hFFFF_FFFF;
               else if (ovf) return 32'h8000_0000;
               else return $signed(a) / $signed(b);
      2'd1:    if (b == 0) return 32'hFFFF_FFFF;
               else return a / b;
      2'd2:    if (b == 0) return a;
               else if (ovf) return 32'd0;
               else return $signed(a) % $signed(b);
      default: if (b == 0) return a;
               else return a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compare whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    exp_t e;
    held_now = 0;
    if (rst_n && !flush && resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp_valid", resp_valid, 0);
      end else begin
        e = sb[0];
        chk("resp_rd", resp_rd, e.rd);
        chk("resp_data", resp_data, e.data);
        if (resp_ready) begin
          chk("latency", cyc - e.acc_cyc - (hold_count - e.hold_at), LAT);
          void'(sb.pop_front());
        end else begin
          held_now = 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (held_now) hold_count++;
  end

  // One clock of stimulus: sample at negedge, push accepted work, then
  // return 1 time unit after the next rising edge.
  task automatic step(output bit acc);
    bit   head_due;
    exp_t e;
    acc = 0;
    @(negedge clk);
    if (!rst_n || flush) begin
      if (rst_n) chk("ready_during_flush", req_ready, 0);
      sb.delete();
    end else begin
      head_due = (sb.size() != 0) &&
                 (cyc >= sb[0].acc_cyc + int'(LAT) + (hold_count - sb[0].hold_at));
      chk("req_ready", req_ready, !(head_due && !resp_ready));
      if (req_valid && req_ready) begin
        e.rd      = req_rd;
        e.data    = ref_result(req_op, req_rs1, req_rs2);
        e.acc_cyc = cyc;
        e.hold_at = hold_count;
        sb.push_back(e);
        acc = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(acc);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    bit acc;
    int n;
    n = 0;
    req_valid = 1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("accept_timeout", acc, 1);
    req_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    resp_ready = 1;
    req_valid  = 0;
    flush      = 0;
    while (sb.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    chk("drain_outstanding", sb.size(), 0);
  endtask

  initial begin
    bit acc;
    int n;
    rst_n = 0; req_valid = 0; req_op = 0; req_rs1 = 0; req_rs2 = 0; req_rd = 0;
    flush = 0; resp_ready = 1;
    idle(2);
    rst_n = 1;
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_req_ready", req_ready, 1);

    // Signed divide with negative dividend.
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5);
    drain();

    // Back-to-back unsigned remainder then quotient.
    issue(OP_REMU, 32'd100, 32'd7, 5'd1);
    issue(OP_DIVU, 32'd100, 32'd7, 5'd2);
    drain();

    // Divide by zero, signed overflow and unsigned corner cases.
    issue(OP_DIV,  32'hFFFF_FFFB, 32'd0, 5'd3);
    issue(OP_REM,  32'hFFFF_FFFB, 32'd0, 5'd4);
    issue(OP_DIVU, 32'd1234, 32'd0, 5'd6);
    issue(OP_REMU, 32'hDEAD_BEEF, 32'd0, 5'd7);
    issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd10);
    issue(OP_REM,  32'd7, 32'hFFFF_FFFE, 5'd11);
    drain();

    // Backpressure: three ops, stall the first response for four cycles
    // while decode offers another request that must not be taken.
    issue(OP_DIV,  32'd50, 32'd5, 5'd12);
    issue(OP_REMU, 32'd51, 32'd5, 5'd13);
    issue(OP_DIVU, 32'd52, 32'd5, 5'd14);
    resp_ready = 0;
    n = 0;
    while (!resp_valid && n < 50) begin
      idle(1);
      n++;
    end
    chk("hold_first_valid", resp_valid, 1);
    req_valid = 1; req_op = OP_DIVU; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_rd = 5'd20;
    repeat (4) begin
      step(acc);
      chk("hold_no_accept", acc, 0);
      chk("hold_req_ready", req_ready, 0);
    end
    resp_ready = 1;
    n = 0;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 50);
    chk("held_request_accepted", acc, 1);
    drain();

    // Flush: three accepted, fourth presented alongside flush, new op after.
    issue(OP_DIV, 32'd90, 32'd9, 5'd21);
    issue(OP_DIV, 32'd91, 32'd9, 5'd22);
    issue(OP_DIV, 32'd92, 32'd9, 5'd23);
    req_valid = 1; req_op = OP_DIV; req_rs1 = 32'd93; req_rs2 = 32'd9; req_rd = 5'd24;
    flush = 1;
    step(acc);
    chk("flush_no_accept", acc, 0);
    flush = 0;
    issue(OP_REMU, 32'd77, 32'd10, 5'd25);
    drain();

    // Reset with five operations in flight.
    issue(OP_DIVU, 32'd10, 32'd2, 5'd26);
    issue(OP_DIVU, 32'd11, 32'd2, 5'd27);
    issue(OP_DIVU, 32'd12, 32'd2, 5'd28);
    issue(OP_DIVU, 32'd13, 32'd2, 5'd29);
    issue(OP_DIVU, 32'd14, 32'd2, 5'd30);
    rst_n = 0;
    idle(1);
    rst_n = 1;
    repeat (10) begin
      chk("post_reset_resp_valid", resp_valid, 0);
      chk("post_reset_req_ready", req_ready, 1);
      idle(1);
    end

    // Randomized traffic with backpressure and occasional flush.
    for (int c = 0; c < 3000; c++) begin
      if (!req_valid && $urandom_range(0, 3) != 0) begin
        req_valid = 1;
        req_op    = 2'($urandom_range(0, 3));
        req_rs1   = pick_operand();
        req_rs2   = pick_operand();
        req_rd    = 5'($urandom_range(0, 31));
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 99) == 0);
      step(acc);
      if (acc) req_valid = 0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 Parameter: DIV_LATENCY, default 8; register stages of the divider datapath.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset: one clock, synchronous, active-low.
REQ-004 req_valid  input  1  decode presents a divide operation.
REQ-005 req_ready  output  1  controller accepts the request this cycle.
REQ-006 req_op  input  2  operation code: 0 DIV, 1 DIVU, 2 REM, 3 REMU.
REQ-007 req_rs1  input  32  dividend operand.
REQ-008 req_rs2  input  32  divisor operand.
REQ-009 req_rd  input  5  destination register tag.
REQ-010 flush  input  1  kill all in-flight operations.
REQ-011 resp_valid  output  1  result available.
REQ-012 resp_ready  input  1  writeback accepts the result.
REQ-013 resp_rd  output  5  destination tag of the result.
REQ-014 resp_data  output  32  quotient or remainder, per the opcode.

Function
REQ-015 The block SHALL instantiate one DividerPipelined and drive these divider inputs:
- i_signed = ~req_op[0];
- i_dividend = req_rs1;
- i_divisor = req_rs2;
- stall = hold;
- rst = ~rst_n.
REQ-016 The block SHALL keep a DIV_LATENCY-entry shadow pipe aligned with the divider stages; each entry holds {v, rd, is_rem, dz}.
REQ-017 Entry 0 SHALL load the following, and advance only when hold=0:
- v = req_valid & req_ready;
- rd = req_rd;
- is_rem = req_op[1];
- dz = (req_rs2 == 0) & ~req_op[1].
REQ-018 hold SHALL equal v[DIV_LATENCY-1] & ~resp_ready; while hold=1 the shadow pipe and the divider are both frozen.
REQ-019 req_ready SHALL equal ~hold & ~flush.
REQ-020 resp_valid SHALL equal v[DIV_LATENCY-1]; resp_rd SHALL equal rd[DIV_LATENCY-1].
REQ-021 resp_data SHALL be selected as follows:
- is_rem=1: divider o_remainder;
- else dz=1: 32'hFFFF_FFFF;
- else: divider o_quotient.
REQ-022 Latency SHALL be exactly DIV_LATENCY cycles from request acceptance to resp_valid when there is no backpressure.
REQ-023 Throughput SHALL be one operation per cycle; idle cycles insert bubbles (v=0).
REQ-024 Divide-by-zero remainder SHALL equal req_rs1, taken from the divider unmodified, for both REM and REMU.
REQ-025 Signed overflow, 0x8000_0000 / 0xFFFF_FFFF, SHALL give quotient 0x8000_0000 and remainder 0; no override is applied.
REQ-026 flush=1 SHALL clear every v bit at the next edge, take precedence over hold, and accept no request that cycle; divider data is left unchanged.
REQ-027 A response held with resp_valid=1 and resp_ready=0 SHALL keep resp_rd and resp_data stable until the handshake completes.
REQ-028 A request arriving while hold=1 SHALL see req_ready=0 and SHALL NOT be lost: decode holds it.

Reset
REQ-029 With rst_n=0 at a clock edge, every v bit SHALL clear; resp_valid=0 and req_ready=1 thereafter.
REQ-030 Reset mid-operation SHALL discard all in-flight operations; no response is produced for them.
REQ-031 After reset, resp_rd and resp_data are don't-care while resp_valid=0.

Structure
REQ-032 The shared package SHALL hold:
- the div_op_t encoding (DIV, DIVU, REM, REMU);
- DIV_LATENCY;
- the shadow-entry struct type.
REQ-033 The single sub-module SHALL be DividerPipelined; the shadow pipe SHALL be inline registers, not a separate module.

Verification
REQ-034 DIV, rs1=-7 (0xFFFF_FFF9), rs2=2, rd=5, resp_ready=1 -> at cycle 8 resp_valid=1, resp_rd=5, resp_data=0xFFFF_FFFD (-3).
REQ-035 REMU then DIVU back-to-back, rs1=100, rs2=7 -> cycles 8 and 9 give 2 then 14.
REQ-036 DIV, rs1=-5, rs2=0 -> 0xFFFF_FFFF; REM, rs1=-5, rs2=0 -> 0xFFFF_FFFB.
REQ-037 Issue 3 ops, hold resp_ready=0 for 4 cycles from the first response -> the first result stays stable, req_ready=0 throughout, then all 3 drain in order with no loss.
REQ-038 Issue 4 ops, flush at cycle 3 -> no resp_valid ever; a new op issued at cycle 4 returns at cycle 12.
REQ-039 rst_n=0 with 5 ops in flight -> resp_valid=0 for the next 10 cycles and req_ready=1 after reset.
